// File: rtl/piezo_pkg.sv
// Note divider codes, sequencer state encoding and the per-channel melody table
// shared by the piezo melody sequencer.
package piezo_pkg;

    localparam int NOTE_DO   = 3830;
    localparam int NOTE_RE   = 3400;
    localparam int NOTE_MI   = 3038;
    localparam int NOTE_FA   = 2864;
    localparam int NOTE_SO   = 2550;
    localparam int NOTE_LA   = 2272;
    localparam int NOTE_TI   = 2028;
    localparam int NOTE_HDO  = 1912;
    localparam int NOTE_REST = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        N_REST, N_DO, N_RE, N_MI, N_FA, N_SO, N_LA, N_TI, N_HDO
    } note_e;

    // Unknown channels and steps past the fourth note are silent.
    function automatic note_e melody_rom(input logic [2:0] ch, input logic [3:0] step);
        note_e n;
        n = N_REST;
        case (ch)
            3'd0: case (step)
                4'd0: n = N_DO;
                4'd1: n = N_MI;
                4'd2: n = N_SO;
                4'd3: n = N_HDO;
                default: n = N_REST;
            endcase
            3'd1: case (step)
                4'd0: n = N_RE;
                4'd1: n = N_FA;
                4'd2: n = N_LA;
                default: n = N_REST;
            endcase
            3'd2: case (step)
                4'd0: n = N_MI;
                4'd1: n = N_SO;
                4'd2: n = N_TI;
                default: n = N_REST;
            endcase
            3'd3: case (step)
                4'd0: n = N_DO;
                4'd2: n = N_DO;
                default: n = N_REST;
            endcase
            default: n = N_REST;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles its output every div/2 clocks while enabled;
// a clear or a rest code parks it low with the half-period counter at zero.
module piezo_tone_gen #(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             clr,
    input  logic             en,
    output logic             piezo
);

    logic [DIV_W-2:0] half;
    logic [DIV_W-2:0] half_last;
    logic [DIV_W-2:0] half_cnt_q, half_cnt_d;
    logic             piezo_q, piezo_d;
    logic             run;

    always_comb begin
        half       = div[DIV_W-1:1];
        half_last  = half - (DIV_W-1)'(1);
        run        = en && (div > DIV_W'(1));
        half_cnt_d = half_cnt_q;
        piezo_d    = piezo_q;
        if (clr || !run) begin
            half_cnt_d = '0;
            piezo_d    = 1'b0;
        end else if (half_cnt_q == half_last) begin
            half_cnt_d = '0;
            piezo_d    = ~piezo_q;
        end else begin
            half_cnt_d = half_cnt_q + (DIV_W-1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_cnt_q <= '0;
            piezo_q    <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            piezo_q    <= piezo_d;
        end
    end

    assign piezo = piezo_q;

endmodule

// File: rtl/piezo_melody_seq.sv
// Trigger-driven melody sequencer: edge-detects channel requests, plays the
// channel's melody note by note and keeps one pending request for back-to-back play.
module piezo_melody_seq
    import piezo_pkg::*;
#(
    parameter int               NUM_CH   = 4,
    parameter int               SEQ_LEN  = 4,
    parameter int               NOTE_CYC = 100000,
    parameter int               DIV_W    = 12,
    parameter logic [DIV_W-1:0] DIV_DO   = DIV_W'(NOTE_DO),
    parameter logic [DIV_W-1:0] DIV_RE   = DIV_W'(NOTE_RE),
    parameter logic [DIV_W-1:0] DIV_MI   = DIV_W'(NOTE_MI),
    parameter logic [DIV_W-1:0] DIV_FA   = DIV_W'(NOTE_FA),
    parameter logic [DIV_W-1:0] DIV_SO   = DIV_W'(NOTE_SO),
    parameter logic [DIV_W-1:0] DIV_LA   = DIV_W'(NOTE_LA),
    parameter logic [DIV_W-1:0] DIV_TI   = DIV_W'(NOTE_TI),
    parameter logic [DIV_W-1:0] DIV_HDO  = DIV_W'(NOTE_HDO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig,
    input  logic              mute,
    output logic              piezo,
    output logic              busy,
    output logic              done,
    output logic [2:0]        cur_ch
);

    localparam int NC_W = $clog2(NOTE_CYC);
    localparam int ST_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [NC_W-1:0] NOTE_LAST = NC_W'(NOTE_CYC - 1);
    localparam logic [ST_W-1:0] STEP_LAST = ST_W'(SEQ_LEN - 1);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] trig_q, trig_prev_q, trig_prev_d, edge_vec;
    logic              hist_vld_q;
    logic [NC_W-1:0]   note_cnt_q, note_cnt_d;
    logic [ST_W-1:0]   step_q, step_d;
    logic [2:0]        cur_ch_q, cur_ch_d, pend_ch_q, pend_ch_d, win_ch;
    logic              pend_vld_q, pend_vld_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              win_vld, note_end, mel_end;
    note_e             note;
    logic [DIV_W-1:0]  div;
    logic              tone_en, tone_piezo;

    always_comb begin
        // Until one sample has been taken after reset, history tracks the input
        // so a level already high at release never looks like an edge.
        trig_prev_d = hist_vld_q ? trig_q : trig;
        edge_vec    = trig_q & ~trig_prev_q;
        win_vld     = 1'b0;
        win_ch      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (edge_vec[i]) begin
                win_vld = 1'b1;
                win_ch  = 3'(i);
            end
        end

        note_end   = (state_q == ST_PLAY) && (note_cnt_q == NOTE_LAST);
        mel_end    = note_end && (step_q == STEP_LAST);
        state_d    = state_q;
        note_cnt_d = note_cnt_q;
        step_d     = step_q;
        cur_ch_d   = cur_ch_q;
        pend_vld_d = pend_vld_q;
        pend_ch_d  = pend_ch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_PLAY;
                    cur_ch_d   = win_ch;
                    step_d     = '0;
                    note_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_PLAY: begin
                if (win_vld) begin
                    pend_vld_d = 1'b1;
                    pend_ch_d  = win_ch;
                end
                if (note_end) begin
                    note_cnt_d = '0;
                    step_d     = step_q + ST_W'(1);
                end else begin
                    note_cnt_d = note_cnt_q + NC_W'(1);
                end
                // A request landing in this very cycle is already in pend_*_d.
                if (mel_end) begin
                    done_d = 1'b1;
                    step_d = '0;
                    if (pend_vld_d) begin
                        cur_ch_d   = pend_ch_d;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d  = ST_IDLE;
                        busy_d   = 1'b0;
                        cur_ch_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        note = melody_rom(cur_ch_q, 4'(step_q));
        case (note)
            N_DO:    div = DIV_DO;
            N_RE:    div = DIV_RE;
            N_MI:    div = DIV_MI;
            N_FA:    div = DIV_FA;
            N_SO:    div = DIV_SO;
            N_LA:    div = DIV_LA;
            N_TI:    div = DIV_TI;
            N_HDO:   div = DIV_HDO;
            default: div = DIV_W'(NOTE_REST);
        endcase
        tone_en = (state_q == ST_PLAY) && !mute;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            trig_q      <= '0;
            trig_prev_q <= '0;
            hist_vld_q  <= 1'b0;
            note_cnt_q  <= '0;
            step_q      <= '0;
            cur_ch_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_ch_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig;
            trig_prev_q <= trig_prev_d;
            hist_vld_q  <= 1'b1;
            note_cnt_q  <= note_cnt_d;
            step_q      <= step_d;
            cur_ch_q    <= cur_ch_d;
            pend_vld_q  <= pend_vld_d;
            pend_ch_q   <= pend_ch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    piezo_tone_gen #(.DIV_W(DIV_W)) u_tone (
        .clk   (clk),
        .rst   (rst),
        .div   (div),
        .clr   (note_end),
        .en    (tone_en),
        .piezo (tone_piezo)
    );

    // Mute gates the output directly so silence is immediate.
    assign piezo  = tone_piezo & ~mute;
    assign busy   = busy_q;
    assign done   = done_q;
    assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Directed bench for piezo_melody_seq: stimulus pushes expected melody events and
// per-cycle piezo levels into queues; a negedge monitor pops and compares them.
module tb_piezo_melody_seq;

    localparam int NUM_CH   = 4;
    localparam int SEQ_LEN  = 4;
    localparam int NOTE_CYC = 8;
    localparam int DIV_W    = 12;
    localparam int MEL_CYC  = SEQ_LEN * NOTE_CYC;
    localparam logic [1:0] K_START = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;
    // Hand-written note dividers per channel/step (DO=8, MI=12 in this bench).
    localparam int MEL [4][4] = '{'{8, 12, 2550, 1912},
                                  '{3400, 2864, 2272, 0},
                                  '{12, 2550, 2028, 0},
                                  '{8, 0, 8, 0}};

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              mute = 1'b0;
    logic [NUM_CH-1:0] trig = '0;
    logic              piezo, busy, done;
    logic [2:0]        cur_ch;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   k;
    logic busy_prev = 1'b0;
    logic [20:0] exp_q[$];       // {kind, ch, cycle}
    logic [16:0] exp_tone_q[$];  // {cycle, piezo}

    piezo_melody_seq #(
        .NUM_CH(NUM_CH), .SEQ_LEN(SEQ_LEN), .NOTE_CYC(NOTE_CYC), .DIV_W(DIV_W),
        .DIV_DO(12'd8), .DIV_MI(12'd12)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .mute(mute),
        .piezo(piezo), .busy(busy), .done(done), .cur_ch(cur_ch)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got time-out required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- expected model ----------------
    function automatic logic tone_exp(input int ch, input int step, input int off);
        int div, half;
        div = MEL[ch][step];
        if (div < 2) return 1'b0;
        half = div / 2;
        return ((off / half) % 2) == 1;
    endfunction

    task automatic push_melody(input int ch, input int t0, input int ncyc,
                               input int m_lo, input int m_hi);
        exp_q.push_back({K_START, 3'(ch), 16'(t0)});
        for (int i = 0; i < ncyc; i++) begin
            logic v;
            v = tone_exp(ch, i / NOTE_CYC, i % NOTE_CYC);
            if (t0 + i >= m_lo && t0 + i <= m_hi) v = 1'b0;
            exp_tone_q.push_back({16'(t0 + i), v});
        end
        if (ncyc == MEL_CYC) exp_q.push_back({K_DONE, 3'd0, 16'(t0 + ncyc)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m, output int kk);
        kk   = cyc + 1;
        trig = m;
        tick(1);
        trig = '0;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check_event(input logic [1:0] kind, input logic [2:0] ch);
        logic [20:0] got, want;
        got = {kind, ch, 16'(cyc)};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected got kind=%0d ch=%0d cyc=%0d required none",
                     kind, ch, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL event got kind=%0d ch=%0d cyc=%0d required kind=%0d ch=%0d cyc=%0d",
                         kind, ch, cyc, want[20:19], want[18:16], want[15:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] tw;
        if (!rst) begin
            busy_prev = 1'b0;
        end else begin
            if (done) check_event(K_DONE, 3'd0);
            if (busy && (!busy_prev || done)) check_event(K_START, cur_ch);
            if (exp_tone_q.size() != 0 && int'(exp_tone_q[0][16:1]) == cyc) begin
                tw = exp_tone_q.pop_front();
                n_tests++;
                if (piezo !== tw[0]) begin
                    n_fail++;
                    $display("FAIL piezo cyc=%0d got=%b required=%b", cyc, piezo, tw[0]);
                end
            end
            busy_prev = busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b0;
        #3;
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_done", int'(done), 0);
        check_val("reset_cur_ch", int'(cur_ch), 0);
        check_val("reset_piezo", int'(piezo), 0);
        tick(3);
        rst = 1'b1;
        tick(4);

        // Single ch0 melody: start k+1, done k+33, tones DO/MI.
        pulse(4'b0001, k);
        push_melody(0, k + 1, MEL_CYC, -1, -1);
        wait_to(k + 40);

        // Simultaneous ch1/ch2: lowest index plays, ch2 dropped.
        pulse(4'b0110, k);
        push_melody(1, k + 1, MEL_CYC, -1, -1);
        wait_to(k + 40);

        // ch3 then ch2 during ch0: ch2 overwrites pending and follows directly.
        pulse(4'b0001, k);
        push_melody(0, k + 1, MEL_CYC, -1, -1);
        wait_to(k + 4);
        pulse(4'b1000, k);
        wait_to(k + 9);
        pulse(4'b0100, k);
        push_melody(2, k + 18, MEL_CYC, -1, -1);
        wait_to(k + 55);

        // Edge in the final cycle of a ch3 melody starts ch1 immediately.
        pulse(4'b1000, k);
        push_melody(3, k + 1, MEL_CYC, -1, -1);
        wait_to(k + 31);
        pulse(4'b0010, k);
        push_melody(1, k + 1, MEL_CYC, -1, -1);
        wait_to(k + 40);

        // Re-trigger of ch0 is queued; mute during the high half of the first note.
        pulse(4'b0001, k);
        push_melody(0, k + 1, MEL_CYC, -1, -1);
        wait_to(k + 9);
        pulse(4'b0001, k);
        push_melody(0, k + 23, MEL_CYC, k + 28, k + 30);
        wait_to(k + 28);
        mute = 1'b1;
        wait_to(k + 31);
        mute = 1'b0;
        wait_to(k + 62);

        // Reset during step 2 aborts silently; a held trig at release starts nothing.
        pulse(4'b0001, k);
        push_melody(0, k + 1, 2 * NOTE_CYC, -1, -1);
        wait_to(k + 20);
        rst  = 1'b0;
        trig = 4'b1111;
        #1;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_done", int'(done), 0);
        check_val("abort_cur_ch", int'(cur_ch), 0);
        check_val("abort_piezo", int'(piezo), 0);
        tick(3);
        rst = 1'b1;
        tick(40);
        check_val("held_trig_busy", int'(busy), 0);
        check_val("held_trig_cur_ch", int'(cur_ch), 0);
        trig = '0;
        tick(4);

        check_val("events_left", exp_q.size(), 0);
        check_val("tones_left", exp_tone_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
